egg_timer_countdown: RTL



---
 rtl/egg_timer_pkg.sv | 30 +++
 rtl/bcd_down_digit.sv | 42 ++++
 rtl/egg_timer_countdown.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_pkg.sv
// -----------------------------------------------------------------------------
// egg_timer_pkg
// Shared types and constants for the egg timer countdown core.
//   state_t      : mode state machine encoding (PAUSED only reachable when
//                  EGG_TIMER_PAUSE_EN is defined)
//   bcd_t        : one BCD digit
//   SEC_TENS_MAX : largest legal seconds-tens digit
//   DIGIT_MAX    : largest legal BCD digit
//   clamp_digit  : saturates a digit to a given maximum
// -----------------------------------------------------------------------------
package egg_timer_pkg;

   typedef enum logic [2:0] {
      INIT,
      SETTING,
      RUNNING,
      DONE,
      PAUSED
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t DIGIT_MAX    = 4'd9;

   function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One BCD down-counting digit with synchronous load. Chains into the next
// more significant digit through o_borrow.
//   clk, rst    : clock, asynchronous active-high reset (digit -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one; 0 wraps to MAX
//   o_digit     : current digit value
//   o_borrow    : decrement requested while digit is 0 (combinational)
// Parameter MAX: value the digit wraps to on underflow.
// -----------------------------------------------------------------------------
module bcd_down_digit
   import egg_timer_pkg::*;
#(
   parameter bcd_t MAX = DIGIT_MAX
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  bcd_t i_load_val,
   input  logic i_dec,
   output bcd_t o_digit,
   output logic o_borrow
);

   bcd_t r_digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digit <= '0;
      end else if (i_load) begin
         r_digit <= i_load_val;
      end else if (i_dec) begin
         r_digit <= (r_digit == '0) ? MAX : (r_digit - 4'd1);
      end
   end

   assign o_borrow = i_dec && (r_digit == '0);
   assign o_digit  = r_digit;

endmodule

// File: rtl/egg_timer_countdown.sv
// -----------------------------------------------------------------------------
// egg_timer_countdown
// Mode sequencing and MM:SS countdown core of the egg timer.
//   clk, rst             : clock, asynchronous active-high reset
//   tick                 : 1 Hz one-clk pulse
//   setPress/startPress/cancelPress : debounced one-clk button pulses
//   setting0..setting3   : BCD setting digits (sec units, sec tens,
//                          min units, min tens)
//   running0..running3   : current countdown digits, same order
//   isInit/isSetting/isRunning/isDone : registered one-hot state flags
//   isPaused             : pause indicator (tied 0 without pause support)
//   alarm                : buzzer enable, asserted in DONE
// Parameter ALARM_TICKS (1..255): ticks spent in DONE before returning to INIT.
// Build option: define EGG_TIMER_PAUSE_EN to add the PAUSED state.
// -----------------------------------------------------------------------------
module egg_timer_countdown
   import egg_timer_pkg::*;
#(
   parameter int unsigned ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       setPress,
   input  logic       startPress,
   input  logic       cancelPress,
   input  logic [3:0] setting0,
   input  logic [3:0] setting1,
   input  logic [3:0] setting2,
   input  logic [3:0] setting3,
   output logic [3:0] running0,
   output logic [3:0] running1,
   output logic [3:0] running2,
   output logic [3:0] running3,
   output logic       isInit,
   output logic       isSetting,
   output logic       isRunning,
   output logic       isDone,
   output logic       isPaused,
   output logic       alarm
);

   localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

   state_t     r_state;
   logic [7:0] r_acnt;
   logic       r_isInit;
   logic       r_isSetting;
   logic       r_isRunning;
   logic       r_isDone;
   logic       r_alarm;

   state_t w_next;
   logic   w_load;
   logic   w_load_zero;
   logic   w_dec;
   logic   w_acnt_inc;
   bcd_t   w_clamp [4];
   bcd_t   w_load_val [4];
   bcd_t   w_digit [4];
   logic   w_borrow [4];
   logic   w_set_zero;
   logic   w_run_nonzero;
   logic   w_run_one;
   logic   w_any_press;
   logic   w_acnt_last;

   assign w_clamp[0] = clamp_digit(setting0, DIGIT_MAX);
   assign w_clamp[1] = clamp_digit(setting1, SEC_TENS_MAX);
   assign w_clamp[2] = clamp_digit(setting2, DIGIT_MAX);
   assign w_clamp[3] = clamp_digit(setting3, DIGIT_MAX);

   assign w_set_zero    = (w_clamp[0] == '0) && (w_clamp[1] == '0) &&
                          (w_clamp[2] == '0) && (w_clamp[3] == '0);
   assign w_run_nonzero = (w_digit[0] != '0) || (w_digit[1] != '0) ||
                          (w_digit[2] != '0) || (w_digit[3] != '0);
   // 00:01 is the only value a single tick turns into 00:00
   assign w_run_one     = (w_digit[0] == 4'd1) && (w_digit[1] == '0) &&
                          (w_digit[2] == '0) && (w_digit[3] == '0);
   assign w_any_press   = setPress || startPress || cancelPress;
   assign w_acnt_last   = (r_acnt == ALARM_LAST);

   // Next-state and datapath control; cancel > start > set > tick
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_load_zero = 1'b0;
      w_dec       = 1'b0;
      w_acnt_inc  = 1'b0;
      case (r_state)
         INIT: begin
            if (setPress && !cancelPress) begin
               w_next = SETTING;
            end
         end
         SETTING: begin
            if (cancelPress) begin
               w_next = INIT;
            end else if (startPress && !w_set_zero) begin
               w_load = 1'b1;
               w_next = RUNNING;
            end
         end
         RUNNING: begin
            if (cancelPress) begin
               w_load      = 1'b1;
               w_load_zero = 1'b1;
               w_next      = INIT;
`ifdef EGG_TIMER_PAUSE_EN
            end else if (startPress) begin
               w_next = PAUSED;
`endif
            end else if (tick && w_run_nonzero) begin
               w_dec = 1'b1;
               if (w_run_one) begin
                  w_next = DONE;
               end
            end
         end
         DONE: begin
            if (w_any_press) begin
               w_next = INIT;
            end else if (tick) begin
               if (w_acnt_last) begin
                  w_next = INIT;
               end else begin
                  w_acnt_inc = 1'b1;
               end
            end
         end
`ifdef EGG_TIMER_PAUSE_EN
         PAUSED: begin
            if (cancelPress) begin
               w_load      = 1'b1;
               w_load_zero = 1'b1;
               w_next      = INIT;
            end else if (startPress) begin
               w_next = RUNNING;
            end
         end
`endif
         default: begin
            w_next = INIT;
         end
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         w_load_val[i] = w_load_zero ? '0 : w_clamp[i];
      end
   end

   // State register plus flags decoded from the next state, so each flag
   // lands on the same edge as the state change it reports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= INIT;
         r_acnt      <= '0;
         r_isInit    <= 1'b1;
         r_isSetting <= 1'b0;
         r_isRunning <= 1'b0;
         r_isDone    <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_isInit    <= (w_next == INIT);
         r_isSetting <= (w_next == SETTING);
         r_isRunning <= (w_next == RUNNING) || (w_next == PAUSED);
         r_isDone    <= (w_next == DONE);
         r_alarm     <= (w_next == DONE);
         if (w_next != DONE) begin
            r_acnt <= '0;
         end else if (w_acnt_inc) begin
            r_acnt <= r_acnt + 8'd1;
         end
      end
   end

`ifdef EGG_TIMER_PAUSE_EN
   logic r_isPaused;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_isPaused <= 1'b0;
      end else begin
         r_isPaused <= (w_next == PAUSED);
      end
   end
   assign isPaused = r_isPaused;
`else
   assign isPaused = 1'b0;
`endif

   // Borrow chain: each digit decrements when the one below underflows
   bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_units (
      .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_load_val[0]),
      .i_dec(w_dec), .o_digit(w_digit[0]), .o_borrow(w_borrow[0])
   );
   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_load_val[1]),
      .i_dec(w_borrow[0]), .o_digit(w_digit[1]), .o_borrow(w_borrow[1])
   );
   bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_units (
      .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_load_val[2]),
      .i_dec(w_borrow[1]), .o_digit(w_digit[2]), .o_borrow(w_borrow[2])
   );
   // Top digit never underflows because decrements stop at 00:00
   bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
      .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(w_load_val[3]),
      .i_dec(w_borrow[2]), .o_digit(w_digit[3]), .o_borrow(w_borrow[3])
   );

   assign running0  = w_digit[0];
   assign running1  = w_digit[1];
   assign running2  = w_digit[2];
   assign running3  = w_digit[3];
   assign isInit    = r_isInit;
   assign isSetting = r_isSetting;
   assign isRunning = r_isRunning;
   assign isDone    = r_isDone;
   assign alarm     = r_alarm;

endmodule
